// File: rtl/button_event_queue_pkg.sv
// rtl/button_event_queue_pkg.sv - shared sizes, button indices and code type for the button event queue
package button_event_queue_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int FIFO_DEPTH  = 4;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t BTN_DEPOSIT  = 2'd0;
  localparam btn_code_t BTN_WITHDRAW = 2'd1;
  localparam btn_code_t BTN_CONFIRM  = 2'd2;
  localparam btn_code_t BTN_CANCEL   = 2'd3;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter, lowest pending index at or after rr_ptr wins
module rr_arbiter4
  import button_event_queue_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  input  logic       enable,
  output logic       grant_valid,
  output btn_code_t  grant_idx
);

  // Scan offsets from farthest to nearest so the closest requester overwrites the others.
  always_comb begin
    logic [1:0] w_idx;
    grant_valid = 1'b0;
    grant_idx   = BTN_DEPOSIT;
    w_idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = rr_ptr + 2'(k);
      if (enable && req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - edge-detects button presses, arbitrates them round-robin into a 4-entry event FIFO
module button_event_queue #(
  parameter int NUM_BUTTONS = button_event_queue_pkg::NUM_BUTTONS,
  parameter int FIFO_DEPTH  = button_event_queue_pkg::FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] debounce,
  output logic [NUM_BUTTONS-1:0] acknowledge,
  output logic                   event_valid,
  output logic [1:0]             event_code,
  input  logic                   event_read,
  output logic                   overflow,
  input  logic                   overflow_clear
);
  import button_event_queue_pkg::*;

  logic [NUM_BUTTONS-1:0] r_prev;
  logic [NUM_BUTTONS-1:0] r_pending;
  logic [1:0]             r_rd_ptr;
  logic [1:0]             r_wr_ptr;
  logic [1:0]             r_rr_ptr;
  logic [2:0]             r_count;
  logic                   r_overflow;
  btn_code_t              r_fifo [FIFO_DEPTH];

  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_grant_oh;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_enable;
  logic                   w_grant_valid;
  btn_code_t              w_grant_idx;
  logic                   w_drop;

  assign w_rise   = debounce & ~r_prev;
  assign w_full   = (r_count == 3'(FIFO_DEPTH));
  assign w_pop    = event_read & (r_count != 3'd0);
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_enable = ~w_full | w_pop;

  rr_arbiter4 u_arb (
    .req         (r_pending),
    .rr_ptr      (r_rr_ptr),
    .enable      (w_enable),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_grant_oh = {NUM_BUTTONS{w_grant_valid}} & (NUM_BUTTONS'(1) << w_grant_idx);
  assign w_drop     = |(w_rise & r_pending & ~w_grant_oh);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '1;
      r_pending  <= '0;
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_rr_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      r_prev     <= debounce;
      r_pending  <= (r_pending & ~w_grant_oh) | w_rise;
      r_overflow <= w_drop | (r_overflow & ~overflow_clear);
      if (w_grant_valid) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
        r_rr_ptr <= w_grant_idx + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_grant_valid, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_grant_valid) begin
      r_fifo[r_wr_ptr] <= w_grant_idx;
    end
  end

  assign event_valid = (r_count != 3'd0);
  assign event_code  = r_fifo[r_rd_ptr];
  assign acknowledge = ~r_pending & {NUM_BUTTONS{~w_full}};
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_button_event_queue.sv
// tb/tb_button_event_queue.sv - scoreboard bench for button_event_queue with a queue-based reference model
module tb_button_event_queue;

  logic       clock;
  logic       reset_n;
  logic [3:0] debounce;
  logic [3:0] acknowledge;
  logic       event_valid;
  logic [1:0] event_code;
  logic       event_read;
  logic       overflow;
  logic       overflow_clear;

  int n_checks = 0;
  int n_pass   = 0;

  bit [3:0] m_prev;
  bit [3:0] m_pending;
  int       m_rr;
  bit       m_ovf;
  int       exp_q[$];

  button_event_queue #(.NUM_BUTTONS(4), .FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .debounce       (debounce),
    .acknowledge    (acknowledge),
    .event_valid    (event_valid),
    .event_code     (event_code),
    .event_read     (event_read),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Reference model: presses wait in a pending set, the head of the event queue is what the processor sees.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_prev    = 4'hF;
      m_pending = 4'h0;
      m_rr      = 0;
      m_ovf     = 1'b0;
      exp_q.delete();
    end else begin
      bit [3:0] rise;
      bit       pop;
      bit       room;
      bit       drop;
      int       g;
      rise   = debounce & ~m_prev;
      m_prev = debounce;
      pop    = event_read && (exp_q.size() > 0);
      room   = (exp_q.size() < 4) || pop;
      g      = -1;
      if (room) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && m_pending[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        end
      end
      drop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (rise[i] && m_pending[i] && g != i) drop = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back(g);
        m_pending[g] = 1'b0;
        m_rr = (g + 1) % 4;
      end
      m_pending = m_pending | rise;
      m_ovf = drop || (m_ovf && !overflow_clear);
    end
  end

  // Monitor: compares what the DUT presents against the scoreboard head and model flags.
  always @(posedge clock) begin
    bit [3:0] exp_ack;
    #1;
    exp_ack = (exp_q.size() < 4) ? ~m_pending : 4'h0;
    check("event_valid", int'(event_valid), int'(exp_q.size() != 0));
    if (event_valid && exp_q.size() > 0) check("event_code", int'(event_code), exp_q[0]);
    check("acknowledge", int'(acknowledge), int'(exp_ack));
    check("overflow", int'(overflow), int'(m_ovf));
  end

  task automatic cyc(input logic [3:0] d, input logic rd, input logic clr);
    @(negedge clock);
    debounce       = d;
    event_read     = rd;
    overflow_clear = clr;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) cyc(4'h0, rd, 1'b0);
  endtask

  initial begin
    logic [3:0] d;
    debounce       = 4'h0;
    event_read     = 1'b0;
    overflow_clear = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // single press on line 2, then read it
    cyc(4'b0100, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // line 3 press brings the round-robin pointer back to 0
    cyc(4'b1000, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);

    // simultaneous presses on 0, 1, 3 drain in order
    cyc(4'b1011, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(4, 1'b1);

    // fill the FIFO, then a press that waits for a pop
    cyc(4'b1111, 1'b0, 1'b0);
    idle(5, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // drop while pending and full; clear in the same cycle as a drop
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0);

    // drain and keep reading while empty
    idle(9, 1'b1);

    // push and pop together at count 2
    cyc(4'b0011, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b1);

    // three queued, then asynchronous reset with buttons held high
    cyc(4'b0111, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    check("pre_reset_valid", int'(event_valid), 1);
    reset_n = 1'b0;
    #1;
    check("async_valid", int'(event_valid), 0);
    check("async_ack", int'(acknowledge), 15);
    check("async_ovf", int'(overflow), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) cyc(4'b1111, 1'b0, 1'b0);
    idle(3, 1'b1);

    // randomized traffic with varying read pressure
    for (int n = 0; n < 1500; n++) begin
      d = debounce;
      if ($urandom_range(0, 2) == 0) d = d ^ 4'($urandom);
      cyc(d, ($urandom_range(0, 9) < ((n / 300) % 2 == 0 ? 3 : 8)), ($urandom_range(0, 15) == 0));
    end
    idle(8, 1'b1);

    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
